// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the serial transmitter and receiver.
// Contents: FSM state enum, parity-mode constants, baud divider and counter-width helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider producing a one-cycle tick every CLKS_PER_BIT enabled cycles.
// Ports: clk, rst (async, active high), clr (sync clear), en (count enable),
//        tick (high for one cycle at terminal count CLKS_PER_BIT-1).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = cnt_width(CLKS_PER_BIT);

    logic [W-1:0] cnt;

    assign tick = en && cnt == W'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready to LSB-first serial frame transmitter (start, data, optional parity, stop).
// Ports: CLK, RST (async, active high), TX_DATA (payload, latched on acceptance),
//        TX_VALID/TX_READY (handshake, ready only when idle), TXD (registered line, idle high),
//        BUSY (frame in progress, inverse of TX_READY).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TXD,
    output logic                 BUSY
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    // Any mode other than even/odd, including the unused encoding 3, sends no parity bit.
    localparam bit PAR_EN = PARITY != PAR_NONE && PARITY <= PAR_ODD;

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t               state, state_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 par, par_n;
    logic [3:0]           idx, idx_n;
    logic                 txd_n;
    logic                 tick;
    logic                 accept;

    assign TX_READY = state == ST_IDLE;
    assign BUSY     = !TX_READY;
    assign accept   = TX_READY && TX_VALID;

    uart_baud_gen #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clk (CLK),
        .rst (RST),
        .clr (accept),
        .en  (state != ST_IDLE),
        .tick(tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            sh    <= '0;
            par   <= 1'b0;
            idx   <= '0;
            TXD   <= 1'b1;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            par   <= par_n;
            idx   <= idx_n;
            TXD   <= txd_n;
        end
    end

    // TXD is registered, so each branch sets the line level of the bit being entered.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        par_n   = par;
        idx_n   = idx;
        txd_n   = TXD;
        case (state)
            ST_IDLE: begin
                if (TX_VALID) begin
                    state_n = ST_START;
                    sh_n    = TX_DATA;
                    par_n   = (^TX_DATA) ^ (PARITY == PAR_ODD);
                    idx_n   = '0;
                    txd_n   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n = ST_DATA;
                    txd_n   = sh[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx == 4'(DATA_BITS - 1)) begin
                        state_n = PAR_EN ? ST_PARITY : ST_STOP;
                        txd_n   = PAR_EN ? par : 1'b1;
                        idx_n   = '0;
                    end else begin
                        sh_n  = sh >> 1;
                        txd_n = sh[1];
                        idx_n = idx + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_n = ST_STOP;
                    txd_n   = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_n = idx == 4'(STOP_BITS - 1) ? ST_IDLE : ST_STOP;
                    idx_n   = idx == 4'(STOP_BITS - 1) ? 4'd0 : idx + 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx across several parity/stop configurations.
module tb_uart_tx;

    localparam int NCFG = 5;
    localparam int PAR_T [NCFG] = '{0, 1, 2, 1, 3};
    localparam int STOP_T[NCFG] = '{1, 1, 1, 2, 1};
    localparam int CPB = 10;

    typedef struct {
        int         k;
        logic [7:0] d;
        bit         ab;
        int         gap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [7:0]      data = 8'h00;
    logic [NCFG-1:0] valid = '0;
    logic [NCFG-1:0] rdy, txd, busy;

    exp_t exp_q[$];
    int   checks = 0, errors = 0, pushed = 0, done = 0, cyc = 0;
    int   last_start[NCFG];
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NCFG; i++) begin : g_dut
        uart_tx #(
            .CLK_FREQ (1000000),
            .BAUD     (100000),
            .DATA_BITS(8),
            .PARITY   (PAR_T[i]),
            .STOP_BITS(STOP_T[i])
        ) u_dut (
            .CLK     (clk),
            .RST     (rst),
            .TX_DATA (data),
            .TX_VALID(valid[i]),
            .TX_READY(rdy[i]),
            .TXD     (txd[i]),
            .BUSY    (busy[i])
        );
    end

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", nm, act, act, req, req, $time);
        end
    endtask

    // Checks one frame on instance k, starting at the negedge where its start bit was first seen.
    task automatic watch_frame(input int k);
        exp_t e;
        bit   lv[$];
        int   start = cyc;
        int   bad = 0, rbad = 0, n = 0;
        if (exp_q.size() == 0) begin
            chk(1'b0, "spurious_frame_on_instance", k, -1);
            while (!rdy[k] && n < 300) begin
                @(negedge clk);
                n++;
            end
            return;
        end
        e = exp_q.pop_front();
        chk(e.k == k, "frame_instance", k, e.k);
        if (e.gap != 0)
            chk(start - last_start[k] == e.gap, "start_edge_gap", start - last_start[k], e.gap);
        last_start[k] = start;
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(e.d[i]);
        if (PAR_T[e.k] == 1 || PAR_T[e.k] == 2) lv.push_back((^e.d) ^ (PAR_T[e.k] == 2));
        repeat (STOP_T[e.k]) lv.push_back(1'b1);
        for (int c = 0; c < lv.size() * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) begin
                chk(e.ab, "abort_by_reset_expected", 1, int'(e.ab));
                done++;
                return;
            end
            if (txd[k] !== lv[c / CPB]) bad++;
            if (rdy[k] !== 1'b0 || busy[k] !== 1'b1) rbad++;
            if (c % CPB == CPB - 1) begin
                chk(bad == 0, $sformatf("bit%0d_samples_off_level_%0d_data_%02h", c / CPB, lv[c / CPB], e.d), bad, 0);
                bad = 0;
            end
        end
        chk(rbad == 0, "ready_low_busy_high_cycles_off", rbad, 0);
        @(negedge clk);
        chk(rdy[k] === 1'b1 && busy[k] === 1'b0, "ready_back_after_frame", int'(rdy[k]), 1);
        chk(txd[k] === 1'b1, "line_idle_after_frame", int'(txd[k]), 1);
        if (e.ab) chk(1'b0, "frame_not_aborted", 0, 1);
        done++;
    endtask

    initial begin : monitor
        logic [NCFG-1:0] prev;
        prev = '1;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < NCFG; k++) begin
                    if (prev[k] && !txd[k]) begin
                        watch_frame(k);
                        break;
                    end
                end
            end
            prev = rst ? '1 : txd;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!((&rdy) && exp_q.size() == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk(1'b0, "idle_timeout", int'(rdy), (1 << NCFG) - 1);
    endtask

    task automatic send(input int k, input logic [7:0] d, input bit ab);
        wait_idle();
        data     = d;
        valid[k] = 1'b1;
        exp_q.push_back('{k: k, d: d, ab: ab, gap: 0});
        pushed++;
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    initial begin : stim
        int n;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk(txd === '1, "reset_txd_async", int'(txd), (1 << NCFG) - 1);
        chk(rdy === '1, "reset_ready_async", int'(rdy), (1 << NCFG) - 1);
        chk(busy === '0, "reset_busy_async", int'(busy), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk(txd === '1, "post_reset_txd", int'(txd), (1 << NCFG) - 1);
        chk(rdy === '1, "post_reset_ready", int'(rdy), (1 << NCFG) - 1);
        chk(busy === '0, "post_reset_busy", int'(busy), 0);
        mon_en = 1'b1;

        send(0, 8'hA5, 1'b0);

        // Back-to-back with TX_VALID held: switch payload when the block becomes ready again.
        wait_idle();
        data     = 8'h00;
        valid[0] = 1'b1;
        exp_q.push_back('{k: 0, d: 8'h00, ab: 1'b0, gap: 0});
        pushed++;
        @(negedge clk);
        n = 0;
        while (!rdy[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk(1'b0, "back_to_back_ready_timeout", 0, 1);
        data = 8'hFF;
        exp_q.push_back('{k: 0, d: 8'hFF, ab: 1'b0, gap: 10 * CPB + 1});
        pushed++;
        @(negedge clk);
        valid[0] = 1'b0;

        for (int k = 1; k < NCFG; k++) send(k, 8'h07, 1'b0);

        // Payload changes after acceptance and a request during data bit 4 must both be ignored.
        send(0, 8'h96, 1'b0);
        data = 8'h69;
        repeat (51) @(negedge clk);
        chk(rdy[0] === 1'b0, "busy_not_ready_in_data_bit4", int'(rdy[0]), 0);
        data     = 8'h3C;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;

        // Reset during data bit 3 aborts the frame.
        send(0, 8'hC3, 1'b1);
        repeat (45) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk(txd[0] === 1'b1, "midframe_reset_txd", int'(txd[0]), 1);
        chk(rdy[0] === 1'b1, "midframe_reset_ready", int'(rdy[0]), 1);
        chk(busy[0] === 1'b0, "midframe_reset_busy", int'(busy[0]), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        send(0, 8'h55, 1'b0);

        repeat (12) send(int'($urandom_range(0, NCFG - 1)), 8'($urandom), 1'b0);

        wait_idle();
        n = 0;
        while (done != pushed && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(done == pushed, "frames_checked", done, pushed);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
